led_pio_pwm_blink: RTL and testbench

// - Avalon-MM slave output port driving a WIDTH-bit LED bank; successor to the fixed 10-bit LED PIO.
// - Adds atomic bit set/clear, per-bit blink enable from a programmable prescaler tick, and global PWM brightness.
// - Sits on the system interconnect, zero wait states, read latency 0; out_port drives board LEDs.

---
 rtl/led_pio_pkg.sv | 15 +
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_pio_pwm_blink.sv | 117 +++++++++++
 tb/tb_led_pio_pwm_blink.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO with PWM/blink: register addresses and STATUS bit positions.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam int STAT_PHASE_BIT = 0;
    localparam int STAT_PWM_BIT   = 1;

endpackage

// File: rtl/led_tick_gen.sv
// Blink prescaler: down-counter that pulses tick when it reaches zero and reloads PERIOD.
// A PERIOD write loads the new value straight into the counter and swallows that cycle's tick,
// so the next tick lands exactly PERIOD_new+1 clocks after the write.
module led_tick_gen #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // Next count: reload on write, reload on terminal count, otherwise count down.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q - PRESCALE_W'(1);
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = period;
        end
    end

    // Counter state; starts at zero so the first tick follows reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pio_pwm_blink.sv
// Avalon-MM LED output port: DATA with atomic set/clear, per-bit blink from a prescaler tick,
// and global PWM brightness. Zero wait states, combinational read data, registered LED drive.
module led_pio_pwm_blink
    import led_pio_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int PRESCALE_W = 24,
    parameter int DUTY_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      blink_en_q, blink_en_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [DUTY_W-1:0]     duty_q, duty_d;
    logic [DUTY_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                  phase_q, phase_d;
    logic [WIDTH-1:0]      out_q, out_d;

    logic                  wr_en;
    logic                  period_load;
    logic                  tick;
    logic                  pwm_on;
    logic [WIDTH-1:0]      wd_bits;
    logic                  unused_wd;

    assign wr_en       = chipselect & ~write_n;
    assign period_load = wr_en && (address == ADDR_PERIOD);
    assign wd_bits     = writedata[WIDTH-1:0];
    assign unused_wd   = ^writedata;

    led_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .period   (period_q),
        .load     (period_load),
        .load_val (writedata[PRESCALE_W-1:0]),
        .tick     (tick)
    );

    // Register file write decode, including the read-modify-write set/clear aliases of DATA.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        duty_d     = duty_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = wd_bits;
                ADDR_BLINK_EN: blink_en_d = wd_bits;
                ADDR_PERIOD:   period_d   = writedata[PRESCALE_W-1:0];
                ADDR_DUTY:     duty_d     = writedata[DUTY_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | wd_bits;
                ADDR_OUTCLEAR: data_d     = data_q & ~wd_bits;
                default:       ;
            endcase
        end
    end

    // PWM compare, blink phase and the next LED drive; all-ones DUTY forces the LEDs fully on.
    always_comb begin
        pwm_on    = (duty_q == '1) || (pwm_cnt_q < duty_q);
        pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
        phase_d   = tick ? ~phase_q : phase_q;
        out_d     = data_q & {WIDTH{pwm_on}} & (~blink_en_q | {WIDTH{phase_q}});
    end

    // All state flops; reset returns every register to its documented reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_en_q <= '0;
            period_q   <= '1;
            duty_q     <= '1;
            pwm_cnt_q  <= '0;
            phase_q    <= 1'b1;
            out_q      <= '0;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
        end
    end

    assign out_port = out_q;

    // Combinational, zero-extended read mux; write-only and reserved addresses read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blink_en_q;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
            ADDR_DUTY:     readdata[DUTY_W-1:0]     = duty_q;
            ADDR_STATUS: begin
                readdata[STAT_PHASE_BIT] = phase_q;
                readdata[STAT_PWM_BIT]   = pwm_on;
            end
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pio_pwm_blink.sv
// Directed bench for led_pio_pwm_blink with default parameters (WIDTH 10, PRESCALE_W 24, DUTY_W 8).
module tb_led_pio_pwm_blink;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int checks = 0;
    int errors = 0;
    int hi_cnt;
    int st_cnt;

    always #5 clk = ~clk;

    led_pio_pwm_blink dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_check(input logic [2:0] a, input string tag, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #12;
        check("reset_out", 32'(out_port), 32'h0);
        rd_check(3'd0, "reset_data", 32'h0);
        rd_check(3'd1, "reset_blink", 32'h0);
        rd_check(3'd2, "reset_period", 32'h00FF_FFFF);
        rd_check(3'd3, "reset_duty", 32'h0000_00FF);
        rd_check(3'd6, "reset_status", 32'h3);
        @(negedge clk);
        reset_n = 1'b1;

        // Legacy behaviour: out_port follows DATA one clock after the write edge.
        wr(3'd0, 32'h0000_02A5);
        check("data_latency", 32'(out_port), 32'h0);
        @(negedge clk);
        check("data_out", 32'(out_port), 32'h2A5);
        rd_check(3'd0, "data_read", 32'h0000_02A5);

        // Atomic set/clear.
        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h003);
        wr(3'd5, 32'h030);
        rd_check(3'd0, "setclr_data", 32'h0C3);
        rd_check(3'd4, "outset_read", 32'h0);
        rd_check(3'd5, "outclr_read", 32'h0);
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h0);
        rd_check(3'd0, "setclr_zero", 32'h0C3);
        wr(3'd7, 32'hFFFF_FFFF);
        rd_check(3'd7, "rsvd_read", 32'h0);
        rd_check(3'd0, "rsvd_nowrite", 32'h0C3);
        @(negedge clk);
        check("setclr_out", 32'(out_port), 32'h0C3);

        // Blink: phase went to 0 on the first tick after reset and has not ticked since.
        wr(3'd0, 32'h003);
        wr(3'd1, 32'h001);
        wr(3'd2, 32'h3);
        address = 3'd6;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("blink_phase_k%0d", k), 32'(readdata[0]), 32'((k >> 2) & 1));
            check($sformatf("blink_out_k%0d", k), 32'(out_port),
                  (k == 0) ? 32'h2 : (32'h2 | 32'(((k - 1) >> 2) & 1)));
        end
        repeat (4) @(negedge clk);
        // Counter is at zero here; the PERIOD write must swallow this tick.
        address = 3'd2; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 3'd6;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            check($sformatf("reload_phase_j%0d", j), 32'(readdata[0]), (j == 6) ? 32'h1 : 32'h0);
        end
        rd_check(3'd2, "period_read", 32'h5);

        // PWM brightness over a full 256-clock window.
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h1);
        wr(3'd3, 32'd64);
        rd_check(3'd3, "duty_read", 32'd64);
        address = 3'd6;
        repeat (2) @(negedge clk);
        hi_cnt = 0; st_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            hi_cnt += int'(out_port[0]);
            st_cnt += int'(readdata[1]);
        end
        check("pwm64_out", 32'(hi_cnt), 32'd64);
        check("pwm64_status", 32'(st_cnt), 32'd64);

        wr(3'd3, 32'd0);
        repeat (2) @(negedge clk);
        hi_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            hi_cnt += int'(out_port[0]);
        end
        check("pwm0_out", 32'(hi_cnt), 32'd0);

        wr(3'd3, 32'd255);
        repeat (2) @(negedge clk);
        hi_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            hi_cnt += int'(out_port[0]);
        end
        check("pwm255_out", 32'(hi_cnt), 32'd256);

        // Asynchronous reset in the middle of blinking.
        wr(3'd1, 32'h001);
        wr(3'd0, 32'h3FF);
        wr(3'd2, 32'h1);
        repeat (5) @(negedge clk);
        check("pre_reset_out", 32'(out_port[9:1]), 32'h1FF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out_port), 32'h0);
        rd_check(3'd0, "rst_data", 32'h0);
        rd_check(3'd1, "rst_blink", 32'h0);
        rd_check(3'd2, "rst_period", 32'h00FF_FFFF);
        rd_check(3'd3, "rst_duty", 32'h0000_00FF);
        rd_check(3'd6, "rst_status", 32'h3);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
